// File: rtl/aes_kat_pkg.sv
// Shared definitions for the AES known-answer-test sequencer: FSM state
// encoding, vector function codes, legal key widths and small helpers.
package aes_kat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } kat_state_t;

    localparam logic [1:0] FUNC_SKIP = 2'b00;
    localparam logic [1:0] FUNC_ENC  = 2'b01;
    localparam logic [1:0] FUNC_DEC  = 2'b10;
    localparam logic [1:0] FUNC_BOTH = 2'b11;

    localparam int KEY_W_128 = 128;
    localparam int KEY_W_192 = 192;
    localparam int KEY_W_256 = 256;

    function automatic logic key_w_legal(input int w);
        return (w == KEY_W_128) || (w == KEY_W_192) || (w == KEY_W_256);
    endfunction

    // Result counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/aes_kat_sequencer_if.sv
// Bundle of the vector-table read port and the AES core request/response
// port. The sequencer uses the master view; the table and core use slave.
interface aes_kat_sequencer_if #(
    parameter int NUM_VEC = 8,
    parameter int KEY_W   = 128
);
    localparam int IDX_W = $clog2(NUM_VEC);

    // vector table
    logic [IDX_W-1:0] vec_idx;
    logic [1:0]       vec_func;
    logic [127:0]     vec_text;
    logic [KEY_W-1:0] vec_key;
    logic [127:0]     vec_expect;

    // AES core
    logic [1:0]       core_func;
    logic [127:0]     core_text;
    logic [KEY_W-1:0] core_key;
    logic             core_start;
    logic             core_done;
    logic [127:0]     core_ciphertext;
    logic [127:0]     core_plaintext;

    modport master (
        output vec_idx, core_func, core_text, core_key, core_start,
        input  vec_func, vec_text, vec_key, vec_expect,
        input  core_done, core_ciphertext, core_plaintext
    );

    modport slave (
        input  vec_idx, core_func, core_text, core_key, core_start,
        output vec_func, vec_text, vec_key, vec_expect,
        output core_done, core_ciphertext, core_plaintext
    );
endinterface

// File: rtl/aes_kat_compare.sv
// Combinational pass/fail decision for one known-answer vector.
module aes_kat_compare
    import aes_kat_pkg::*;
(
    input  logic [1:0]   func,
    input  logic [127:0] ciphertext,
    input  logic [127:0] plaintext,
    input  logic [127:0] exp_val,
    input  logic [127:0] text,
    output logic         match
);

    // Select which core result(s) must agree with the table for this function.
    always_comb begin
        match = 1'b1;
        case (func)
            FUNC_ENC:  match = (ciphertext == exp_val);
            FUNC_DEC:  match = (plaintext == exp_val);
            FUNC_BOTH: match = (ciphertext == exp_val) && (plaintext == text);
            default:   match = 1'b1;
        endcase
    end

endmodule

// File: rtl/aes_kat_sequencer.sv
// Walks an external table of AES known-answer vectors, issues each one to
// the AES core, checks the result and keeps pass/fail statistics.
// Optional feature macro: AES_KAT_TIMEOUT_EN -- when defined, a vector whose
// core never answers within TIMEOUT_CYC cycles is scored as a failure.
module aes_kat_sequencer
    import aes_kat_pkg::*;
#(
    parameter int NUM_VEC     = 8,
    parameter int KEY_W       = 128,
    parameter int TIMEOUT_CYC = 64,
    localparam int IDX_W      = $clog2(NUM_VEC)
) (
    input  logic                 eph1,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 loop,
    aes_kat_sequencer_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 fail_flag,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          fail_cnt,
    output logic [IDX_W-1:0]     first_fail_idx
);

    // Out-of-range parameter sets leave a visible marker scope in the hierarchy.
    if (!key_w_legal(KEY_W) || (NUM_VEC < 2) || (NUM_VEC > 256) || (TIMEOUT_CYC < 1)) begin : g_illegal_params
    end

    kat_state_t       state_r;
    kat_state_t       state_s;
    logic             start_run_s;
    logic             load_s;
    logic             capture_s;
    logic             check_s;
    logic             last_s;
    logic             match_s;
    logic             verdict_ok_s;

    logic [IDX_W-1:0] vec_idx_r;
    logic [1:0]       core_func_r;
    logic [127:0]     core_text_r;
    logic [KEY_W-1:0] core_key_r;
    logic             core_start_r;
    logic [127:0]     expect_r;
    logic [127:0]     ct_r;
    logic [127:0]     pt_r;
    logic             busy_r;
    logic             done_r;
    logic             fail_flag_r;
    logic [15:0]      pass_cnt_r;
    logic [15:0]      fail_cnt_r;
    logic [IDX_W-1:0] first_fail_idx_r;
    logic             first_seen_r;

`ifdef AES_KAT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
    logic [TMR_W-1:0] timer_r;
    logic             timeout_s;
    logic             tmo_r;
`endif

    assign last_s = (vec_idx_r == IDX_W'(NUM_VEC - 1));

`ifdef AES_KAT_TIMEOUT_EN
    assign verdict_ok_s = match_s && !tmo_r;
`else
    assign verdict_ok_s = match_s;
`endif

    aes_kat_compare u_compare (
        .func       (core_func_r),
        .ciphertext (ct_r),
        .plaintext  (pt_r),
        .exp_val    (expect_r),
        .text       (core_text_r),
        .match      (match_s)
    );

    // FSM state register.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and the per-cycle strobes that drive the datapath.
    always_comb begin
        state_s     = state_r;
        start_run_s = 1'b0;
        load_s      = 1'b0;
        capture_s   = 1'b0;
        check_s     = 1'b0;
`ifdef AES_KAT_TIMEOUT_EN
        timeout_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_s     = ST_FETCH;
                    start_run_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                load_s = 1'b1;
                if (bus.vec_func == FUNC_SKIP) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.core_done) begin
                    capture_s = 1'b1;
                    state_s   = ST_CHECK;
                end
`ifdef AES_KAT_TIMEOUT_EN
                else if (timer_r == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = ST_CHECK;
                end
`endif
                else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CHECK: begin
                check_s = 1'b1;
                if (!last_s) begin
                    state_s = ST_FETCH;
                end else if (loop) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

`ifdef AES_KAT_TIMEOUT_EN
    // Cycles spent waiting on the core, and whether the current vector timed out.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            timer_r <= '0;
            tmo_r   <= 1'b0;
        end else begin
            if (state_r == ST_WAIT) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= '0;
            end
            if (load_s) begin
                tmo_r <= 1'b0;
            end else if (timeout_s) begin
                tmo_r <= 1'b1;
            end
        end
    end
`endif

    // Vector index, core request registers, result capture and statistics.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            vec_idx_r        <= '0;
            core_func_r      <= 2'b00;
            core_text_r      <= 128'd0;
            core_key_r       <= '0;
            core_start_r     <= 1'b0;
            expect_r         <= 128'd0;
            ct_r             <= 128'd0;
            pt_r             <= 128'd0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            fail_flag_r      <= 1'b0;
            pass_cnt_r       <= 16'd0;
            fail_cnt_r       <= 16'd0;
            first_fail_idx_r <= '0;
            first_seen_r     <= 1'b0;
        end else begin
            busy_r       <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r       <= (state_s == ST_DONE);
            core_start_r <= (state_s == ST_ISSUE);

            if (start_run_s) begin
                vec_idx_r        <= '0;
                pass_cnt_r       <= 16'd0;
                fail_cnt_r       <= 16'd0;
                fail_flag_r      <= 1'b0;
                first_fail_idx_r <= '0;
                first_seen_r     <= 1'b0;
            end

            // Core inputs stay frozen from here until the vector is checked.
            if (load_s) begin
                core_func_r <= bus.vec_func;
                core_text_r <= bus.vec_text;
                core_key_r  <= bus.vec_key;
                expect_r    <= bus.vec_expect;
            end

            // Core results are only valid alongside core_done.
            if (capture_s) begin
                ct_r <= bus.core_ciphertext;
                pt_r <= bus.core_plaintext;
            end

            if (check_s && (core_func_r != FUNC_SKIP)) begin
                if (verdict_ok_s) begin
                    pass_cnt_r <= sat_inc16(pass_cnt_r);
                end else begin
                    fail_cnt_r  <= sat_inc16(fail_cnt_r);
                    fail_flag_r <= 1'b1;
                    if (!first_seen_r) begin
                        first_fail_idx_r <= vec_idx_r;
                        first_seen_r     <= 1'b1;
                    end
                end
            end

            // Advance; a wrap starts a new pass so first-failure capture re-arms.
            if (check_s) begin
                if (!last_s) begin
                    vec_idx_r <= vec_idx_r + IDX_W'(1);
                end else if (loop) begin
                    vec_idx_r    <= '0;
                    first_seen_r <= 1'b0;
                end
            end
        end
    end

    assign bus.vec_idx    = vec_idx_r;
    assign bus.core_func  = core_func_r;
    assign bus.core_text  = core_text_r;
    assign bus.core_key   = core_key_r;
    assign bus.core_start = core_start_r;

    assign busy           = busy_r;
    assign done           = done_r;
    assign fail_flag      = fail_flag_r;
    assign pass_cnt       = pass_cnt_r;
    assign fail_cnt       = fail_cnt_r;
    assign first_fail_idx = first_fail_idx_r;

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Self-checking bench for aes_kat_sequencer: a vector table, a behavioural
// stand-in for the AES core, and a verdict scoreboard fed on each core_start.
module tb_aes_kat_sequencer;
    import aes_kat_pkg::*;

    localparam int NV = 8;
    localparam int KW = 128;
    localparam int IW = $clog2(NV);
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MIX      = 128'ha5a5_5a5a_c3c3_3c3c_0f0f_f0f0_9696_6969;

    logic          eph1 = 1'b0;
    logic          reset;
    logic          go;
    logic          loop;
    logic          busy;
    logic          done;
    logic          fail_flag;
    logic [15:0]   pass_cnt;
    logic [15:0]   fail_cnt;
    logic [IW-1:0] first_fail_idx;

    int n_vec  = 0;
    int n_miss = 0;

    int lat  = 2;
    bit hold = 1'b0;

    int n_start = 0;
    int starts_at [NV];
    int cyc = 0;
    int last_start = -1;
    int min_gap = 1000000;
    int max_gap = 0;

    typedef struct { int idx; bit ok; } sb_t;
    sb_t sbq [$];
    sb_t sb_e;
    logic [15:0] prev_p = 16'd0;
    logic [15:0] prev_f = 16'd0;

    logic [1:0]   t_func [NV];
    logic [127:0] t_text [NV];
    logic [127:0] t_key  [NV];
    logic [127:0] t_exp  [NV];
    bit           t_good [NV];

    logic [1:0]   cm_f;
    logic [127:0] cm_x;
    logic [127:0] cm_k;

    aes_kat_sequencer_if #(.NUM_VEC(NV), .KEY_W(KW)) bus ();

    aes_kat_sequencer #(.NUM_VEC(NV), .KEY_W(KW), .TIMEOUT_CYC(64)) dut (
        .eph1           (eph1),
        .reset          (reset),
        .go             (go),
        .loop           (loop),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .fail_flag      (fail_flag),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx)
    );

    always #5 eph1 = ~eph1;

    assign bus.vec_func   = t_func[bus.vec_idx];
    assign bus.vec_text   = t_text[bus.vec_idx];
    assign bus.vec_key    = t_key[bus.vec_idx];
    assign bus.vec_expect = t_exp[bus.vec_idx];

    // Stand-in cipher: exact FIPS-197 answer for the reference vector,
    // otherwise an invertible scramble so encrypt/decrypt round-trip.
    function automatic logic [127:0] enc_f(input logic [127:0] x, input logic [127:0] k);
        if (x == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return {x[119:0], x[127:120]} ^ k ^ MIX;
    endfunction

    function automatic logic [127:0] dec_f(input logic [127:0] y, input logic [127:0] k);
        logic [127:0] z;
        if (y == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
        z = y ^ k ^ MIX;
        return {z[7:0], z[127:8]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural AES core: answers lat cycles after core_start unless held.
    initial begin
        bus.core_done       = 1'b0;
        bus.core_ciphertext = 128'd0;
        bus.core_plaintext  = 128'd0;
        forever begin
            @(posedge eph1); #1;
            if (bus.core_start === 1'b1) begin
                cm_f = bus.core_func;
                cm_x = bus.core_text;
                cm_k = bus.core_key;
                repeat (lat) @(posedge eph1);
                #1;
                while (hold) begin
                    @(posedge eph1); #1;
                end
                bus.core_ciphertext = (cm_f == FUNC_DEC) ? 128'd0 : enc_f(cm_x, cm_k);
                bus.core_plaintext  = (cm_f == FUNC_ENC) ? 128'd0 :
                                      (cm_f == FUNC_DEC) ? dec_f(cm_x, cm_k) :
                                      dec_f(enc_f(cm_x, cm_k), cm_k);
                bus.core_done = 1'b1;
                @(posedge eph1); #1;
                bus.core_done = 1'b0;
            end
        end
    end

    // Scoreboard: push the expected verdict when a vector goes to the core,
    // pop it when one of the result counters moves.
    initial begin
        forever begin
            @(negedge eph1);
            cyc++;
            if (bus.core_start === 1'b1) begin
                n_start++;
                starts_at[bus.vec_idx]++;
                chk("core_func", 128'(bus.core_func), 128'(t_func[bus.vec_idx]));
                chk("core_text", bus.core_text, t_text[bus.vec_idx]);
                chk("core_key", bus.core_key, t_key[bus.vec_idx]);
                sbq.push_back('{idx: int'(bus.vec_idx), ok: t_good[bus.vec_idx]});
                if (last_start >= 0) begin
                    if (cyc - last_start < min_gap) min_gap = cyc - last_start;
                    if (cyc - last_start > max_gap) max_gap = cyc - last_start;
                end
                last_start = cyc;
            end
            if (pass_cnt == prev_p + 16'd1 || fail_cnt == prev_f + 16'd1) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_verdict", 128'd0, 128'd1);
                end else begin
                    sb_e = sbq.pop_front();
                    chk($sformatf("verdict_idx%0d", sb_e.idx),
                        128'(pass_cnt == prev_p + 16'd1), 128'(sb_e.ok));
                end
            end
            prev_p = pass_cnt;
            prev_f = fail_cnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic build_fips();
        for (int i = 0; i < NV; i++) begin
            t_func[i] = FUNC_SKIP;
            t_text[i] = 128'd0;
            t_key[i]  = 128'd0;
            t_exp[i]  = 128'd0;
            t_good[i] = 1'b1;
        end
        t_func[0] = FUNC_ENC;
        t_text[0] = FIPS_PT;
        t_key[0]  = FIPS_KEY;
        t_exp[0]  = FIPS_CT;
    endtask

    task automatic build_rand(input int bad, input int skip);
        logic [127:0] p;
        for (int i = 0; i < NV; i++) begin
            p         = {$urandom(), $urandom(), $urandom(), $urandom()};
            t_key[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            t_func[i] = 2'((i % 3) + 1);
            if (t_func[i] == FUNC_DEC) begin
                t_text[i] = enc_f(p, t_key[i]);
                t_exp[i]  = p;
            end else begin
                t_text[i] = p;
                t_exp[i]  = enc_f(p, t_key[i]);
            end
            t_good[i] = (i != bad);
            if (i == bad) t_exp[i][i] = ~t_exp[i][i];
            if (i == skip) t_func[i] = FUNC_SKIP;
        end
    endtask

    task automatic start(input bit lp);
        @(negedge eph1);
        go   = 1'b1;
        loop = lp;
        @(negedge eph1);
        go   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge eph1);
            n++;
        end
        chk("done_within_budget", 128'(done), 128'd1);
    endtask

    task automatic reset_gaps();
        last_start = -1;
        min_gap    = 1000000;
        max_gap    = 0;
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < NV; i++) starts_at[i] = 0;
        reset = 1'b1;
        go    = 1'b0;
        loop  = 1'b0;
        build_fips();
        repeat (3) @(negedge eph1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_vec_idx", 128'(bus.vec_idx), 128'd0);
        chk("rst_core_start", 128'(bus.core_start), 128'd0);
        chk("rst_pass_cnt", 128'(pass_cnt), 128'd0);
        chk("rst_fail_cnt", 128'(fail_cnt), 128'd0);
        reset = 1'b0;
        repeat (2) @(negedge eph1);
        chk("idle_busy", 128'(busy), 128'd0);

        // FIPS-197 reference vector, the rest of the table skipped.
        base = n_start;
        start(1'b0);
        chk("run_busy", 128'(busy), 128'd1);
        wait_done(300);
        chk("fips_pass_cnt", 128'(pass_cnt), 128'd1);
        chk("fips_fail_cnt", 128'(fail_cnt), 128'd0);
        chk("fips_fail_flag", 128'(fail_flag), 128'd0);
        chk("fips_busy", 128'(busy), 128'd0);
        chk("fips_starts", 128'(n_start - base), 128'd1);

        // Core that does not answer.
`ifdef AES_KAT_TIMEOUT_EN
        t_good[0] = 1'b0;
        hold = 1'b1;
        start(1'b0);
        repeat (100) @(negedge eph1);
        chk("tmo_fail_cnt", 128'(fail_cnt), 128'd1);
        chk("tmo_fail_flag", 128'(fail_flag), 128'd1);
        chk("tmo_done", 128'(done), 128'd1);
        hold = 1'b0;
        repeat (6) @(negedge eph1);
        t_good[0] = 1'b1;
`else
        hold = 1'b1;
        start(1'b0);
        repeat (100) @(negedge eph1);
        chk("stall_busy", 128'(busy), 128'd1);
        chk("stall_done", 128'(done), 128'd0);
        chk("stall_fail_cnt", 128'(fail_cnt), 128'd0);
        hold = 1'b0;
        wait_done(300);
        chk("stall_pass_cnt", 128'(pass_cnt), 128'd1);
`endif

        // Index 5 corrupted, single pass, extra go while busy.
        build_rand(5, -1);
        lat = 2;
        reset_gaps();
        base = n_start;
        start(1'b0);
        repeat (7) @(negedge eph1);
        go = 1'b1;
        @(negedge eph1);
        go = 1'b0;
        wait_done(500);
        chk("bad5_pass_cnt", 128'(pass_cnt), 128'd7);
        chk("bad5_fail_cnt", 128'(fail_cnt), 128'd1);
        chk("bad5_first_fail_idx", 128'(first_fail_idx), 128'd5);
        chk("bad5_fail_flag", 128'(fail_flag), 128'd1);
        chk("bad5_starts", 128'(n_start - base), 128'd8);
        chk("bad5_min_gap", 128'(min_gap), 128'd5);
        chk("bad5_max_gap", 128'(max_gap), 128'd5);

        // Index 2 skipped.
        build_rand(-1, 2);
        for (int i = 0; i < NV; i++) starts_at[i] = 0;
        start(1'b0);
        wait_done(500);
        chk("skip2_starts_idx2", 128'(starts_at[2]), 128'd0);
        chk("skip2_starts_idx3", 128'(starts_at[3]), 128'd1);
        chk("skip2_pass_cnt", 128'(pass_cnt), 128'd7);
        chk("skip2_fail_flag", 128'(fail_flag), 128'd0);

        // Looping, three full passes, then loop dropped mid-pass.
        build_rand(-1, -1);
        lat = 4;
        reset_gaps();
        start(1'b1);
        n = 0;
        while (pass_cnt != 16'd17 && n < 1000) begin
            @(negedge eph1);
            n++;
        end
        chk("loop_reach17", 128'(pass_cnt), 128'd17);
        chk("loop_not_done", 128'(done), 128'd0);
        loop = 1'b0;
        wait_done(1000);
        chk("loop_pass_cnt", 128'(pass_cnt), 128'd24);
        chk("loop_fail_cnt", 128'(fail_cnt), 128'd0);
        chk("loop_min_gap", 128'(min_gap), 128'd7);
        chk("loop_max_gap", 128'(max_gap), 128'd7);

        // Reset while waiting on index 3; the late core answer must be ignored.
        lat = 2;
        start(1'b0);
        n = 0;
        while (!(bus.core_start === 1'b1 && bus.vec_idx == IW'(3)) && n < 200) begin
            @(negedge eph1);
            n++;
        end
        hold = 1'b1;
        repeat (2) @(negedge eph1);
        chk("pre_reset_pass_cnt", 128'(pass_cnt), 128'd3);
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", 128'(busy), 128'd0);
        chk("mid_reset_pass_cnt", 128'(pass_cnt), 128'd0);
        chk("mid_reset_vec_idx", 128'(bus.vec_idx), 128'd0);
        chk("mid_reset_core_text", bus.core_text, 128'd0);
        @(negedge eph1);
        reset = 1'b0;
        sbq.delete();
        base = n_start;
        hold = 1'b0;
        repeat (8) @(negedge eph1);
        chk("late_done_pass_cnt", 128'(pass_cnt), 128'd0);
        chk("late_done_fail_cnt", 128'(fail_cnt), 128'd0);
        chk("late_done_busy", 128'(busy), 128'd0);
        chk("late_done_done", 128'(done), 128'd0);
        chk("late_done_starts", 128'(n_start - base), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
